// File: rtl/aes_sub_bytes_seq.sv
// Sequential AES SubBytes: one 128-bit state is substituted SBOX_LANES bytes
// per cycle through shared S-box lanes. Result returned via valid/ready.
// Optional macro AES_SUBBYTES_SHIFTROWS_EN: also applies ShiftRows as output
// wiring (no added latency).

// Single AES S-box lane: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p, xa, zb;
    p  = 8'h00;
    xa = x;
    zb = z;
    for (int i = 0; i < 8; i++) begin
      if (zb[0]) p = p ^ xa;
      xa = {xa[6:0], 1'b0} ^ (xa[7] ? 8'h1b : 8'h00);
      zb = {1'b0, zb[7:1]};
    end
    return p;
  endfunction

  localparam logic [7:0] EXP = 8'hfe;  // 254: a^254 = a^-1, and 0 maps to 0

  logic [7:0] inv;

  // square-and-multiply inverse, then affine transform
  always_comb begin
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gmul(inv, inv);
      if (EXP[i]) inv = gmul(inv, a);
    end
    y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_sub_bytes_seq #(
  parameter int SBOX_LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  localparam int ITER = 16 / SBOX_LANES;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  generate
    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
          SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
      $error("aes_sub_bytes_seq: SBOX_LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} st_t;

  st_t                              state, nxt;
  logic [CW-1:0]                    cnt;
  logic [15:0][7:0]                 work;   // element 15 holds s0
  logic [SBOX_LANES-1:0][7:0]       sb_in, sb_out;
  logic [SBOX_LANES-1:0][3:0]       widx;   // work element touched by each lane
  logic                             last;

  assign last = (cnt == CW'(ITER - 1));

  // lane l handles byte cnt*LANES+l of the current slice
  generate
    for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
      logic [4:0] bidx;
      assign bidx    = 5'(cnt) * 5'(SBOX_LANES) + 5'(l);
      assign widx[l] = 4'(5'd15 - bidx);
      assign sb_in[l] = work[widx[l]];
      aes_sbox u_sbox (.a(sb_in[l]), .y(sb_out[l]));
    end
  endgenerate

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next-state logic; flush overrides everything
  always_comb begin
    nxt = state;
    if (flush) nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (in_valid)  nxt = BUSY;
        BUSY:    if (last)      nxt = DONE;
        DONE:    if (out_ready) nxt = IDLE;
        default:                nxt = IDLE;
      endcase
    end
  end

  // handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == BUSY) || (state == DONE);
  end

  // work register and slice counter; bytes rewritten in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      cnt  <= '0;
    end else if (flush) begin
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work <= in_state;
          cnt  <= '0;
        end
        BUSY: begin
          for (int l = 0; l < SBOX_LANES; l++) work[widx[l]] <= sb_out[l];
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // output byte order; ShiftRows is pure wiring when enabled
`ifdef AES_SUBBYTES_SHIFTROWS_EN
  always_comb begin
    out_state = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        out_state[127-8*(4*c+r) -: 8] = work[15 - (4*((c+r)%4) + r)];
  end
`else
  always_comb begin
    out_state = work;
  end
`endif
endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Bench for aes_sub_bytes_seq: vector table through a scoreboard queue plus
// hand sequences for backpressure, flush and asynchronous reset.
module tb_aes_sub_bytes_seq;
  parameter int SBOX_LANES = 4;
  localparam int ITER = 16 / SBOX_LANES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;
  logic         busy;

  int checks = 0;
  int failures = 0;
  logic [127:0] sb_q[$];

  always #5 clk = ~clk;

  aes_sub_bytes_seq #(.SBOX_LANES(SBOX_LANES)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .busy(busy)
  );

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
    int           hold;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // send one state, check latency, backpressure stability and retirement
  task automatic xfer(input logic [127:0] d, input logic [127:0] e, input int hold);
    int n;
    logic [127:0] want, snap;
    @(negedge clk);
    chk("in_ready_before", {127'd0, in_ready}, 128'd1);
    in_state = d;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    sb_q.push_back(e);
    #1 in_valid = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (out_valid || n > 40) break;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        chk("busy_while_working", {126'd0, busy, in_ready}, 128'd2);
      end
      @(posedge clk);
      n++;
    end
    chk("latency", 128'(n), 128'(ITER));
    want = sb_q.pop_front();
    chk("out_state", out_state, want);
    chk("busy_done", {127'd0, busy}, 128'd1);
    snap = out_state;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_state !== snap)
        chk("stall_stable", {out_valid, out_state[126:0]}, {1'b1, snap[126:0]});
    end
    if (hold > 0) chk("stall_end", out_state, snap);
    // offer a new input during retirement: it must not be taken that cycle
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_state  = ~d;
    @(negedge clk);
    chk("retire", {125'd0, out_valid, in_ready, busy}, 128'b010);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    tbl[0] = '{128'h0, {16{8'h63}}, 0};
`ifdef AES_SUBBYTES_SHIFTROWS_EN
    tbl[1] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 2};
    tbl[3] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h636b6776f201ab7b30d777c5fe7c6f2b, 0};
`else
    tbl[1] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230, 2};
    tbl[3] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76, 0};
`endif
    tbl[2] = '{{16{8'hff}}, {16{8'h16}}, 10};
    tbl[4] = '{{16{8'h01}}, {16{8'h7c}}, 1};

    // reset values
    #12;
    chk("rst_flags", {124'd0, in_ready, out_valid, busy, 1'b0}, 128'b1000);
    chk("rst_out_state", out_state, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) xfer(tbl[i].din, tbl[i].exp, tbl[i].hold);

    // flush and in_valid together in IDLE: nothing accepted
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; in_state = {16{8'haa}};
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle", {126'd0, in_ready, busy}, 128'b10);

    // flush while BUSY: back to IDLE, out_valid never seen
    @(negedge clk);
    in_valid = 1'b1; in_state = {16{8'h55}};
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (ITER >= 2) begin
      @(negedge clk);
      chk("flush_pre_ov", {127'd0, out_valid}, 128'd0);
    end
    @(negedge clk);
    chk("flush_pre_busy", {127'd0, busy}, 128'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {125'd0, in_ready, out_valid, busy}, 128'b100);
    for (int i = 0; i < ITER + 2; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) chk("flush_no_ov", {127'd0, out_valid}, 128'd0);
    end
    xfer(tbl[0].din, tbl[0].exp, 0);

    // asynchronous reset mid-BUSY
    @(negedge clk);
    in_valid = 1'b1; in_state = tbl[1].din;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {125'd0, in_ready, out_valid, busy}, 128'b100);
    chk("async_rst_out", out_state, 128'h0);
    for (int i = 0; i < ITER + 2; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) chk("rst_no_ov", {127'd0, out_valid}, 128'd0);
    end
    rst_n = 1'b1;
    xfer(tbl[1].din, tbl[1].exp, 0);

    if (sb_q.size() != 0) chk("scoreboard_empty", 128'(sb_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
